// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer: runs one 8-bit ADD/SUB/MUL/DIV at a time between
// decode and write-back, holding the result until it is consumed.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, op, a, b
// (request); out_valid/out_ready, result (response); busy; op_count
// (consumed results, wrapping); err (only with ALU_SEQ_ERR_EN defined).
// Params: MUL_CYCLES (1..4) accept-to-valid latency of MUL;
// CNT_W width of op_count.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_SEQ_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_DONE
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_STEPS = 4'd8;

    state_e           state_q, state_d;
    logic             rdy_q;
    logic [1:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       quo_q, quo_d;
    logic [15:0]      res_q, res_d;
    logic [CNT_W-1:0] opc_q, opc_d;

    logic             accept;
    logic             pop;
    logic [8:0]       sum9;
    logic [8:0]       diff9;
    logic [15:0]      prod;
    logic [15:0]      exec_res;
    logic             exec_done;
    logic [8:0]       rem_sh;
    logic [8:0]       rem_sub;
    logic             rem_ge;

    // in_ready is held low until the first edge after reset release.
    assign pop      = (state_q == S_DONE) & out_ready;
    assign in_ready = rdy_q & ((state_q == S_IDLE) | pop);
    assign accept   = in_valid & in_ready;

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;
    assign op_count  = opc_q;

    assign sum9  = {1'b0, a_q} + {1'b0, b_q};
    assign diff9 = {1'b0, a_q} - {1'b0, b_q};
    assign prod  = 16'(a_q) * 16'(b_q);

    // DIV only reaches EXEC when the divisor is zero.
    always_comb begin
        exec_res = 16'h0000;
        unique case (op_q)
            OP_ADD: exec_res = {7'b0, sum9};
            OP_SUB: exec_res = {7'b0, diff9};
            OP_MUL: exec_res = prod;
            OP_DIV: exec_res = {a_q, 8'hFF};
            default: exec_res = 16'h0000;
        endcase
    end

    assign exec_done = (op_q != OP_MUL) | (cnt_q == MUL_LAST);

    // One restoring step: shift in the next dividend bit MSB first,
    // subtract the divisor when it fits.
    assign rem_sh  = {rem_q, quo_q[7]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign rem_ge  = (rem_sh >= {1'b0, b_q});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        opc_d   = opc_q;

        if (pop) begin
            opc_d = opc_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_DONE;
                    res_d   = exec_res;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DIV: begin
                if (cnt_q != DIV_STEPS) begin
                    rem_d = rem_ge ? rem_sub[7:0] : rem_sh[7:0];
                    quo_d = {quo_q[6:0], rem_ge};
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    state_d = S_DONE;
                    res_d   = {rem_q, quo_q};
                end
            end
            S_DONE: begin
                if (pop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new request overrides the pop's return to IDLE (no bubble).
        if (accept) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = 4'd0;
            rem_d   = 8'h00;
            quo_d   = a;
            state_d = ((op == OP_DIV) && (b != 8'h00)) ? S_DIV : S_EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cnt_q   <= 4'd0;
            rem_q   <= 8'h00;
            quo_q   <= 8'h00;
            res_q   <= 16'h0000;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            opc_q   <= opc_d;
        end
    end

`ifdef ALU_SEQ_ERR_EN
    logic err_q, err_d;
    logic exec_err;

    always_comb begin
        exec_err = 1'b0;
        unique case (op_q)
            OP_ADD: exec_err = sum9[8];
            OP_SUB: exec_err = diff9[8];
            OP_MUL: exec_err = 1'b0;
            OP_DIV: exec_err = 1'b1;
            default: exec_err = 1'b0;
        endcase
    end

    // Every path into DONE passes EXEC or DIV, so a pop (with or
    // without a new accept) always clears, and DONE entry sets.
    always_comb begin
        err_d = err_q;
        if (pop) begin
            err_d = 1'b0;
        end
        if ((state_q == S_EXEC) && exec_done) begin
            err_d = exec_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// Directed bench for alu_op_sequencer: table of single ops plus
// hand sequences for reset, backpressure, mid-op reset and wrap.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;
    logic [7:0]  op_count;
`ifdef ALU_SEQ_ERR_EN
    logic        err;
`endif

    int nvec = 0;
    int nmis = 0;
    logic [7:0] exp_cnt = 8'd0;

    alu_op_sequencer #(
        .MUL_CYCLES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy),
        .op_count(op_count)
`ifdef ALU_SEQ_ERR_EN
        ,
        .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input bit check);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (check) chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = v.op;
        a = v.a;
        b = v.b;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = 8'h5A;
        b = 8'hA5;
        n = 0;
        while (!out_valid && n < 20) begin
            if (check) chk("busy", 32'(busy), 32'd1);
            tick();
            n++;
        end
        if (check) begin
            chk("latency", 32'(n), 32'(v.lat));
            chk("result", 32'(result), 32'(v.res));
`ifdef ALU_SEQ_ERR_EN
            chk("err", 32'(err), 32'(v.err));
`endif
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        if (check) begin
            chk("op_count", 32'(op_count), 32'(exp_cnt));
            chk("valid_after_pop", 32'(out_valid), 32'd0);
            chk("result_kept", 32'(result), 32'(v.res));
        end
    endtask

    vec_t v;
    int   t;

    initial begin
        vecs[0]  = '{2'b00, 8'hF0, 8'h20, 16'h0110, 1, 1'b1};
        vecs[1]  = '{2'b00, 8'h12, 8'h34, 16'h0046, 1, 1'b0};
        vecs[2]  = '{2'b01, 8'h03, 8'h05, 16'h01FE, 1, 1'b1};
        vecs[3]  = '{2'b01, 8'h50, 8'h20, 16'h0030, 1, 1'b0};
        vecs[4]  = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 2, 1'b0};
        vecs[5]  = '{2'b10, 8'h0C, 8'h0D, 16'h009C, 2, 1'b0};
        vecs[6]  = '{2'b11, 8'd200, 8'd7, 16'h041C, 9, 1'b0};
        vecs[7]  = '{2'b11, 8'd9, 8'd0, 16'h09FF, 1, 1'b1};
        vecs[8]  = '{2'b11, 8'd255, 8'd1, 16'h00FF, 9, 1'b0};
        vecs[9]  = '{2'b11, 8'd5, 8'd10, 16'h0500, 9, 1'b0};
        vecs[10] = '{2'b11, 8'd100, 8'd10, 16'h000A, 9, 1'b0};
        vecs[11] = '{2'b10, 8'h00, 8'h77, 16'h0000, 2, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 2'b00;
        a = 8'h00;
        b = 8'h00;

        // reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef ALU_SEQ_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready0", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready1", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i], 1'b1);

        // backpressure, then pop and accept in the same cycle
        in_valid = 1'b1;
        op = 2'b01;
        a = 8'd3;
        b = 8'd5;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", 32'(result), 32'h01FE);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b1;
        op = 2'b00;
        a = 8'd1;
        b = 8'd2;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_op_count", 32'(op_count), 32'(exp_cnt));
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_no_valid", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(result), 32'h0003);
`ifdef ALU_SEQ_ERR_EN
        chk("b2b_err", 32'(err), 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("b2b_pop_count", 32'(op_count), 32'(exp_cnt));

        // out_ready with nothing valid
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_ready_count", 32'(op_count), 32'(exp_cnt));

        // reset in the middle of a DIV
        in_valid = 1'b1;
        op = 2'b11;
        a = 8'd200;
        b = 8'd7;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        tick();
        run_op(vecs[6], 1'b1);

        // wrap of op_count
        v = '{2'b00, 8'd1, 8'd1, 16'h0002, 1, 1'b0};
        for (int k = 0; k < 254; k++) run_op(v, 1'b0);
        chk("count_255", 32'(op_count), 32'hFF);
        run_op(v, 1'b1);
        chk("count_wrap", 32'(op_count), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        t = 0;
        while (t < 20000) begin
            @(posedge clk);
            t++;
        end
        $display("FAIL timeout: got %0d cycles expected fewer", t);
        $fatal(1, "timeout");
    end

endmodule
